// File: rtl/event_monitor_pkg.sv
// Shared types for the event monitor: record tones, topics, the default
// record layout and the two FSM state sets.
package monitor_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [2:0] {
      TRACE = 3'd0,
      DEBUG = 3'd1,
      INFO  = 3'd2,
      WARN  = 3'd3,
      ERROR = 3'd4,
      FATAL = 3'd5
   } tone_t;

   typedef enum logic {
      STBL    = 1'b0,
      OBSERVE = 1'b1
   } topic_t;

   typedef struct packed {
      tone_t                level;
      topic_t               topic;
      logic [DEF_CNT_W-1:0] count;
      logic [DEF_WIDTH-1:0] data_a;
      logic [DEF_WIDTH-1:0] data_b;
   } event_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRACK,
      S_LOST
   } stbl_state_t;

   typedef enum logic {
      O_IDLE,
      O_WAIT
   } obs_state_t;

endpackage

// File: rtl/event_monitor_if.sv
// Ready/valid event record stream leaving the monitor.
interface event_monitor_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
);
   logic             evt_valid;
   logic             evt_ready;
   logic [2:0]       evt_level;
   logic             evt_topic;
   logic [CNT_W-1:0] evt_count;
   logic [WIDTH-1:0] evt_data_a;
   logic [WIDTH-1:0] evt_data_b;

   modport master (
      output evt_valid, evt_level, evt_topic, evt_count, evt_data_a, evt_data_b,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_level, evt_topic, evt_count, evt_data_a, evt_data_b,
      output evt_ready
   );
endinterface

// File: rtl/event_monitor_fifo.sv
// Record FIFO with two write slots per cycle (slot a lands first) and one read.
module event_fifo
   import monitor_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type rec_t = event_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_a,
   input  rec_t                   rec_a,
   input  logic                   push_b,
   input  rec_t                   rec_b,
   input  logic                   pop,
   output rec_t                   head,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] free
);
   localparam int unsigned AW = $clog2(DEPTH);

   rec_t          mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   occ;
   logic [AW-1:0] slot_a;
   logic [AW-1:0] slot_b;

   // Free space counts the slot vacated by a same-cycle pop.
   always_comb begin
      occ    = wr_ptr - rd_ptr;
      free   = (AW+1)'(DEPTH) - occ + (AW+1)'(pop);
      slot_a = wr_ptr[AW-1:0];
      slot_b = push_a ? slot_a + AW'(1) : slot_a;
   end

   assign valid = (wr_ptr != rd_ptr);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_a) mem[slot_a] <= rec_a;
      if (push_b) mem[slot_b] <= rec_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (AW+1)'(push_a) + (AW+1)'(push_b);
         rd_ptr <= rd_ptr + (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/event_monitor.sv
// In-fabric checker: flag/data stability and target-arrival windows, reported
// as event records through a small FIFO on a ready/valid stream.
module event_monitor
   import monitor_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag,
   input  logic [WIDTH-1:0] data,
   input  logic             watch,
   input  logic             target,
   input  logic [CNT_W-1:0] limit,
   event_monitor_if.master  evt,
   output logic             overflow,
   output logic             busy
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      tone_t            level;
      topic_t           topic;
      logic [CNT_W-1:0] count;
      logic [WIDTH-1:0] data_a;
      logic [WIDTH-1:0] data_b;
   } rec_t;

   stbl_state_t      s_state, s_next;
   logic [WIDTH-1:0] held, held_next;
   logic [CNT_W-1:0] scnt, scnt_next;
   logic             s_fire;
   rec_t             s_rec;

   obs_state_t       o_state, o_next;
   logic [CNT_W-1:0] lim, lim_next;
   logic [CNT_W-1:0] ocnt, ocnt_next;
   logic             o_fire;
   rec_t             o_rec;

   rec_t             head, shown;
   logic             f_valid, pop, push_a, push_b, drop;
   logic [AW:0]      free;

   always_comb begin
      s_next    = s_state;
      held_next = held;
      scnt_next = scnt;
      s_fire    = 1'b0;
      s_rec     = '{level: INFO, topic: STBL, count: scnt, data_a: held, data_b: '0};
      case (s_state)
         S_IDLE: begin
            if (flag) begin
               held_next = data;
               scnt_next = CNT_W'(1);
               s_next    = S_TRACK;
            end
         end
         S_TRACK: begin
            if (!flag) begin
               s_fire = 1'b1;
               s_next = S_IDLE;
            end else if (data != held) begin
               s_fire       = 1'b1;
               s_rec.level  = ERROR;
               s_rec.data_b = data;
               s_next       = S_LOST;
            end else if (scnt != '1) begin
               scnt_next = scnt + CNT_W'(1);
            end
         end
         S_LOST: begin
            if (!flag) s_next = S_IDLE;
         end
         default: s_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_next    = o_state;
      lim_next  = lim;
      ocnt_next = ocnt;
      o_fire    = 1'b0;
      o_rec     = '{level: INFO, topic: OBSERVE, count: '0, data_a: '0, data_b: '0};
      case (o_state)
         O_IDLE: begin
            if (watch) begin
               if (limit == '0) begin
                  o_fire      = 1'b1;
                  o_rec.level = ERROR;
               end else if (target) begin
                  o_fire = 1'b1;
               end else begin
                  lim_next  = limit;
                  ocnt_next = CNT_W'(1);
                  o_next    = O_WAIT;
               end
            end
         end
         O_WAIT: begin
            if (target) begin
               o_fire      = 1'b1;
               o_rec.count = ocnt;
               o_next      = O_IDLE;
            end else if (ocnt == lim) begin
               o_fire      = 1'b1;
               o_rec.level = ERROR;
               o_rec.count = lim;
               o_next      = O_IDLE;
            end else begin
               ocnt_next = ocnt + CNT_W'(1);
            end
         end
         default: o_next = O_IDLE;
      endcase
   end

   // STBL takes the first free slot; OBSERVE only gets one left over.
   always_comb begin
      pop    = f_valid & evt.evt_ready;
      push_a = s_fire & (free != '0);
      push_b = o_fire & (s_fire ? (free >= (AW+1)'(2)) : (free != '0));
      drop   = (s_fire & ~push_a) | (o_fire & ~push_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_state  <= S_IDLE;
         held     <= '0;
         scnt     <= '0;
         o_state  <= O_IDLE;
         lim      <= '0;
         ocnt     <= '0;
         overflow <= 1'b0;
      end else begin
         s_state  <= s_next;
         held     <= held_next;
         scnt     <= scnt_next;
         o_state  <= o_next;
         lim      <= lim_next;
         ocnt     <= ocnt_next;
         overflow <= overflow | drop;
      end
   end

   event_fifo #(
      .DEPTH (DEPTH),
      .rec_t (rec_t)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_a (push_a),
      .rec_a  (s_rec),
      .push_b (push_b),
      .rec_b  (o_rec),
      .pop    (pop),
      .head   (head),
      .valid  (f_valid),
      .free   (free)
   );

   assign shown          = f_valid ? head : '0;
   assign evt.evt_valid  = f_valid;
   assign evt.evt_level  = shown.level;
   assign evt.evt_topic  = shown.topic;
   assign evt.evt_count  = shown.count;
   assign evt.evt_data_a = shown.data_a;
   assign evt.evt_data_b = shown.data_b;
   assign busy           = (s_state != S_IDLE) || (o_state != O_IDLE);
endmodule

// File: tb/tb_event_monitor.sv
// Scoreboarded bench for event_monitor: run/window reference model feeding an
// expected-record queue, checked by an independent stream monitor.
module tb_event_monitor;
   import monitor_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flag = 1'b0;
   logic [7:0]  data = '0;
   logic        watch = 1'b0;
   logic        target = 1'b0;
   logic [15:0] limit = '0;
   logic        overflow, busy;

   int errors = 0;
   int checks = 0;

   event_monitor_if #(.WIDTH(8), .CNT_W(16)) evt_if ();

   event_monitor #(.WIDTH(8), .CNT_W(16), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flag     (flag),
      .data     (data),
      .watch    (watch),
      .target   (target),
      .limit    (limit),
      .evt      (evt_if),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model state: a stability run is [run_start..], a window is [win_start..].
   event_t sb[$];
   event_t seen[$];
   int     cyc = 0;
   bit     run_on = 0, run_lost = 0;
   int     run_start = 0;
   logic [7:0] run_val = '0;
   bit     win_on = 0;
   int     win_start = 0, win_lim = 0;
   bit     m_ovf = 0, m_busy = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic event_t mk(tone_t l, topic_t t, int c, logic [7:0] a, logic [7:0] b);
      return '{level: l, topic: t, count: 16'(c), data_a: a, data_b: b};
   endfunction

   task automatic model_reset();
      sb.delete();
      run_on = 0; run_lost = 0; win_on = 0; m_ovf = 0; m_busy = 0;
   endtask

   task automatic model_step();
      event_t cand[$];
      int n, free;
      if (!run_on) begin
         if (flag) begin
            run_on = 1; run_lost = 0; run_start = cyc; run_val = data;
         end
      end else if (run_lost) begin
         if (!flag) run_on = 0;
      end else begin
         n = cyc - run_start;
         if (n > 65535) n = 65535;
         if (!flag) begin
            cand.push_back(mk(INFO, STBL, n, run_val, 8'h00));
            run_on = 0;
         end else if (data != run_val) begin
            cand.push_back(mk(ERROR, STBL, n, run_val, data));
            run_lost = 1;
         end
      end
      if (!win_on) begin
         if (watch) begin
            if (limit == 0) cand.push_back(mk(ERROR, OBSERVE, 0, 8'h00, 8'h00));
            else if (target) cand.push_back(mk(INFO, OBSERVE, 0, 8'h00, 8'h00));
            else begin
               win_on = 1; win_start = cyc; win_lim = int'(limit);
            end
         end
      end else begin
         n = cyc - win_start;
         if (target) begin
            cand.push_back(mk(INFO, OBSERVE, n, 8'h00, 8'h00));
            win_on = 0;
         end else if (n == win_lim) begin
            cand.push_back(mk(ERROR, OBSERVE, win_lim, 8'h00, 8'h00));
            win_on = 0;
         end
      end
      free = DEPTH - sb.size();
      foreach (cand[i]) begin
         if (free > 0) begin
            sb.push_back(cand[i]);
            free--;
         end else begin
            m_ovf = 1;
         end
      end
      m_busy = run_on || win_on;
      cyc++;
   endtask

   task automatic step(input logic f, input logic [7:0] d, input logic w, input logic t,
                       input logic [15:0] l, input logic r);
      @(posedge clk); #1;
      flag = f; data = d; watch = w; target = t; limit = l; evt_if.evt_ready = r;
      @(negedge clk); #1;
      if (!rst) model_step();
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 16'd0, r);
   endtask

   // Stream monitor: head must match the oldest expected record; pops on handshake.
   initial begin
      event_t act;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("valid", evt_if.evt_valid, sb.size() != 0);
            chk("overflow", overflow, m_ovf);
            chk("busy", busy, m_busy);
            act = '{level: tone_t'(evt_if.evt_level), topic: topic_t'(evt_if.evt_topic),
                    count: evt_if.evt_count, data_a: evt_if.evt_data_a, data_b: evt_if.evt_data_b};
            if (evt_if.evt_valid && sb.size() != 0) chk("head", act, sb[0]);
            if (evt_if.evt_valid && evt_if.evt_ready) begin
               seen.push_back(act);
               if (sb.size() != 0) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic f;
      logic [7:0] d;
      evt_if.evt_ready = 1'b0;
      #12;
      chk("rst_valid", evt_if.evt_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_fields", {evt_if.evt_level, evt_if.evt_topic, evt_if.evt_count,
                         evt_if.evt_data_a, evt_if.evt_data_b}, 36'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Held data for 5 cycles then release.
      seen.delete();
      for (int i = 0; i < 5; i++) step(1, 8'hA5, 0, 0, 0, 1);
      idle(3, 1);
      chk("held_n", seen.size(), 1);
      if (seen.size() == 1) chk("held_rec", seen[0], mk(INFO, STBL, 5, 8'hA5, 8'h00));
      chk("held_ovf", overflow, 1'b0);

      // Data changes on 3rd cycle of flag.
      seen.delete();
      step(1, 8'h3C, 0, 0, 0, 1);
      step(1, 8'h3C, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 8'h3D, 0, 0, 0, 1);
      idle(3, 1);
      chk("lost_n", seen.size(), 1);
      if (seen.size() == 1) chk("lost_rec", seen[0], mk(ERROR, STBL, 2, 8'h3C, 8'h3D));

      // Observe: hit at 3, timeout at 4, zero limit.
      seen.delete();
      step(0, 0, 1, 0, 16'd4, 1);
      idle(2, 1);
      step(0, 0, 0, 1, 0, 1);
      idle(1, 1);
      step(0, 0, 1, 0, 16'd4, 1);
      idle(5, 1);
      step(0, 0, 1, 0, 16'd0, 1);
      idle(2, 1);
      chk("obs_n", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("obs_hit", seen[0], mk(INFO, OBSERVE, 3, 8'h00, 8'h00));
         chk("obs_timeout", seen[1], mk(ERROR, OBSERVE, 4, 8'h00, 8'h00));
         chk("obs_zero", seen[2], mk(ERROR, OBSERVE, 0, 8'h00, 8'h00));
      end

      // STBL end and OBSERVE hit in the same cycle.
      seen.delete();
      step(1, 8'h55, 1, 0, 16'd5, 1);
      step(1, 8'h55, 0, 0, 0, 1);
      step(0, 8'h00, 0, 1, 0, 1);
      idle(3, 1);
      chk("both_n", seen.size(), 2);
      if (seen.size() == 2) begin
         chk("both_first", seen[0], mk(INFO, STBL, 2, 8'h55, 8'h00));
         chk("both_second", seen[1], mk(INFO, OBSERVE, 2, 8'h00, 8'h00));
      end

      // Six records into a stalled four-entry FIFO.
      seen.delete();
      for (int i = 1; i <= 6; i++) begin
         step(1, 8'(i), 0, 0, 0, 0);
         step(0, 8'h00, 0, 0, 0, 0);
      end
      idle(1, 0);
      chk("full_none_out", seen.size(), 0);
      chk("full_ovf", overflow, 1'b1);
      idle(6, 1);
      chk("full_n", seen.size(), 4);
      if (seen.size() == 4)
         for (int i = 0; i < 4; i++) chk("full_order", seen[i], mk(INFO, STBL, 1, 8'(i + 1), 8'h00));
      chk("full_drained", evt_if.evt_valid, 1'b0);

      // One free slot with both records firing.
      seen.delete();
      for (int i = 1; i <= 3; i++) begin
         step(1, 8'(i + 8'h10), 0, 0, 0, 0);
         step(0, 8'h00, 0, 0, 0, 0);
      end
      step(1, 8'h77, 1, 0, 16'd5, 0);
      step(1, 8'h77, 0, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      idle(6, 1);
      chk("slot_n", seen.size(), 4);
      if (seen.size() == 4) chk("slot_kept", seen[3], mk(INFO, STBL, 2, 8'h77, 8'h00));

      // Reset with both FSMs active and records queued.
      seen.delete();
      for (int i = 0; i < 2; i++) begin
         step(1, 8'h20, 0, 0, 0, 0);
         step(0, 8'h00, 0, 0, 0, 0);
      end
      step(1, 8'h11, 1, 0, 16'd10, 0);
      step(1, 8'h11, 0, 0, 0, 0);
      chk("pre_rst_busy", busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      flag = 0; data = '0; watch = 0; target = 0; limit = '0;
      model_reset();
      #1;
      chk("mid_rst_valid", evt_if.evt_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ovf", overflow, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(5, 1);
      chk("post_rst_quiet", seen.size(), 0);

      // Randomized traffic against the model.
      f = 0;
      d = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) f = ~f;
         if ($urandom_range(0, 9) == 0) d = 8'($urandom);
         step(f, d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
              16'($urandom_range(0, 8)), ($urandom_range(0, 3) != 0));
      end
      idle(12, 1);
      chk("final_drained", evt_if.evt_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
